serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits added per clock; WIDTH SHALL be a multiple of DIGIT, and DIGIT SHALL be at least 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start_valid  input  1  operands and mode presented.
REQ-006 start_ready  output  1  block can accept a new operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 sub  input  1  mode: 0 = add, 1 = subtract.
REQ-011 sum  output  WIDTH  result.
REQ-012 cout  output  1  carry-out of the result MSB.
REQ-013 ovf  output  1  two's-complement signed overflow.
REQ-014 done_valid  output  1  result outputs valid.
REQ-015 done_ready  input  1  consumer accepts the result.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE; start_ready = 1 only in IDLE, and done_valid = 1 only in DONE.
REQ-017 An operation SHALL be accepted on a rising edge where start_valid and start_ready are both 1.
- At accept, a, b, cin and sub are captured into internal registers.
- The inputs are ignored at every other edge.
REQ-018 On accept, the block SHALL set effective B = sub ? ~b : b, set the initial carry = cin XOR sub, clear the digit counter and move IDLE -> RUN.
REQ-019 In RUN, each cycle SHALL add one DIGIT-bit slice, LSB slice first, using the registered carry; the slice sum is stored and the carry-out is registered for the next slice.
REQ-020 RUN SHALL last exactly N = WIDTH/DIGIT cycles; done_valid SHALL rise N cycles after the accept edge, with the move RUN -> DONE.
REQ-021 On the last slice, the block SHALL:
- set cout = carry out of bit WIDTH-1;
- set ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-022 In subtract mode, sum SHALL equal a - b - cin modulo 2^WIDTH, and cout = 1 SHALL mean no borrow.
REQ-023 In DONE, sum, cout and ovf SHALL hold stable until the edge where done_ready = 1; that edge SHALL move DONE -> IDLE and drop done_valid.
REQ-024 A new operation SHALL NOT be accepted in the same cycle as the DONE -> IDLE transition; the minimum spacing between accepts is N+2 cycles.
REQ-025 sum, cout and ovf SHALL keep their last values in IDLE; they are defined only while done_valid = 1.
REQ-026 start_valid and done_ready asserted in RUN SHALL have no effect.
REQ-027 The case DIGIT = WIDTH SHALL be supported: N = 1, and done_valid rises one cycle after accept.

Reset
REQ-028 While rst_n = 0, the block SHALL force:
- state = IDLE;
- sum = 0, cout = 0, ovf = 0;
- done_valid = 0, start_ready = 1;
- digit counter and internal carry = 0.
REQ-029 Reset asserted during RUN or DONE SHALL abort the operation immediately; no partial result is ever presented with done_valid = 1.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-031 With WIDTH=16, DIGIT=4, the bench SHALL cover these directed scenarios:
- add a=0x1234, b=0x4321, cin=0 -> done_valid 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
- add a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- sub a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0, ovf=0; sub a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- done_ready held 0 for 5 cycles in DONE, with new start_valid=1 and changed a/b -> sum/cout/ovf unchanged and start_ready=0; done_ready=1 -> IDLE next cycle, accept on the following edge.
- rst_n pulsed low in the 2nd RUN cycle -> all outputs at reset values at once; no done_valid appears; a subsequent add 0x0001+0x0001 gives 0x0002.
- DIGIT=16 build: add 0xABCD+0x1111 -> sum=0xBCDE one cycle after accept.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
// The master issues operations and consumes results; the slave is the adder.
interface serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             done_valid;
    logic             done_ready;

    modport master (
        output start_valid, a, b, cin, sub, done_ready,
        input  start_ready, sum, cout, ovf, done_valid
    );

    modport slave (
        input  start_valid, a, b, cin, sub, done_ready,
        output start_ready, sum, cout, ovf, done_valid
    );
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB slice first,
// and presents the WIDTH-bit result with carry-out and signed overflow.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    serial_adder_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             cout_r;
    logic             ovf_r;
    logic             start_ready_r;
    logic             done_valid_r;
    logic             accept_s;
    logic             last_s;
    logic [DIGIT:0]   slice_s;
    logic             msb_cin_s;

    assign accept_s  = (state_r == IDLE) && bus.start_valid;
    assign last_s    = (cnt_r == LAST);
    assign slice_s   = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_r};
    // Carry into the slice MSB recovered from the MSB sum bit and its operands.
    assign msb_cin_s = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_s[DIGIT-1];

    // a_r doubles as the result accumulator: slice sums shift in from the top.
    generate
        if (DIGIT < WIDTH) begin : g_multi
            assign a_nxt_s = {slice_s[DIGIT-1:0], a_r[WIDTH-1:DIGIT]};
            assign b_nxt_s = {{DIGIT{1'b0}}, b_r[WIDTH-1:DIGIT]};
        end else begin : g_single
            assign a_nxt_s = slice_s[DIGIT-1:0];
            assign b_nxt_s = {WIDTH{1'b0}};
        end
    endgenerate

    assign bus.start_ready = start_ready_r;
    assign bus.done_valid  = done_valid_r;
    assign bus.sum         = sum_r;
    assign bus.cout        = cout_r;
    assign bus.ovf         = ovf_r;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: if (bus.start_valid) state_nxt_s = RUN;  else state_nxt_s = IDLE;
            RUN:  if (last_s)          state_nxt_s = DONE; else state_nxt_s = RUN;
            DONE: if (bus.done_ready)  state_nxt_s = IDLE; else state_nxt_s = DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, per-slice datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            sum_r         <= {WIDTH{1'b0}};
            cnt_r         <= {CW{1'b0}};
            carry_r       <= 1'b0;
            cout_r        <= 1'b0;
            ovf_r         <= 1'b0;
            start_ready_r <= 1'b1;
            done_valid_r  <= 1'b0;
        end else begin
            start_ready_r <= (state_nxt_s == IDLE);
            done_valid_r  <= (state_nxt_s == DONE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= bus.a;
                        b_r     <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.cin ^ bus.sub;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    a_r     <= a_nxt_s;
                    b_r     <= b_nxt_s;
                    carry_r <= slice_s[DIGIT];
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum_r  <= a_nxt_s;
                        cout_r <= slice_s[DIGIT];
                        ovf_r  <= msb_cin_s ^ slice_s[DIGIT];
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: DIGIT=4 and DIGIT=16 instances driven
// with directed vectors; monitors compare each presented result to the queue.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_if #(.WIDTH(16)) bus4();
    serial_adder_if #(.WIDTH(16)) bus16();

    serial_adder #(.WIDTH(16), .DIGIT(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
    serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
        int          acc;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor for the DIGIT=4 instance.
    logic dv4_q = 1'b0;
    always @(negedge clk) begin : mon4
        exp_t e;
        if (bus4.done_valid && !dv4_q) begin
            if (q4.size() == 0) begin
                chk("dut4_unexpected_done", bus4.done_valid, 0);
            end else begin
                e = q4.pop_front();
                chk("dut4_sum", bus4.sum, e.s);
                chk("dut4_cout", bus4.cout, e.c);
                chk("dut4_ovf", bus4.ovf, e.o);
                chk("dut4_latency", cyc - e.acc, 4);
            end
        end
        dv4_q <= bus4.done_valid;
    end

    // Monitor for the DIGIT=16 instance.
    logic dv16_q = 1'b0;
    always @(negedge clk) begin : mon16
        exp_t e;
        if (bus16.done_valid && !dv16_q) begin
            if (q16.size() == 0) begin
                chk("dut16_unexpected_done", bus16.done_valid, 0);
            end else begin
                e = q16.pop_front();
                chk("dut16_sum", bus16.sum, e.s);
                chk("dut16_cout", bus16.cout, e.c);
                chk("dut16_ovf", bus16.ovf, e.o);
                chk("dut16_latency", cyc - e.acc, 1);
            end
        end
        dv16_q <= bus16.done_valid;
    end

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input bit expect_result,
                         input logic [15:0] es, input logic ec, input logic eo);
        int k = 0;
        while (!(wide ? bus16.start_ready : bus4.start_ready) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (wide) begin
            if (k >= 100) chk("dut16_ready_timeout", bus16.start_ready, 1);
            bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
            bus16.start_valid = 1'b1;
            if (expect_result) q16.push_back('{es, ec, eo, cyc + 1});
            @(posedge clk);
            #1 bus16.start_valid = 1'b0;
        end else begin
            if (k >= 100) chk("dut4_ready_timeout", bus4.start_ready, 1);
            bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.sub = sub;
            bus4.start_valid = 1'b1;
            if (expect_result) q4.push_back('{es, ec, eo, cyc + 1});
            @(posedge clk);
            #1 bus4.start_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_idle4();
        int k = 0;
        while (!bus4.start_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (k >= 100) chk("dut4_idle_timeout", bus4.start_ready, 1);
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        bus4.start_valid = 1'b0;  bus4.a = 16'h0;  bus4.b = 16'h0;
        bus4.cin = 1'b0;  bus4.sub = 1'b0;  bus4.done_ready = 1'b1;
        bus16.start_valid = 1'b0; bus16.a = 16'h0; bus16.b = 16'h0;
        bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.done_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_sum", bus4.sum, 16'h0000);
        chk("reset_cout", bus4.cout, 1'b0);
        chk("reset_ovf", bus4.ovf, 1'b0);
        chk("reset_done_valid", bus4.done_valid, 1'b0);
        chk("reset_start_ready", bus4.start_ready, 1'b1);
        rst_n = 1'b1;

        issue(1'b0, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        issue(1'b0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        issue(1'b0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        issue(1'b0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        issue(1'b0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        issue(1'b0, 16'h00FF, 16'h0F00, 1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
        issue(1'b0, 16'h0010, 16'h0003, 1'b1, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
        issue(1'b0, 16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b1);

        issue(1'b1, 16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b1, 16'hBCDE, 1'b0, 1'b0);
        issue(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Result held in DONE while the consumer stalls and new operands appear.
        wait_idle4();
        bus4.done_ready = 1'b0;
        issue(1'b0, 16'hF000, 16'h2000, 1'b0, 1'b0, 1'b1, 16'h1000, 1'b1, 1'b0);
        k = 0;
        while (!bus4.done_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("hold_done_timeout", bus4.done_valid, 1);
        for (int i = 0; i < 5; i++) begin
            bus4.start_valid = 1'b1; bus4.a = 16'hFFFF; bus4.b = 16'hFFFF;
            @(negedge clk);
            chk("hold_sum", bus4.sum, 16'h1000);
            chk("hold_cout", bus4.cout, 1'b1);
            chk("hold_ovf", bus4.ovf, 1'b0);
            chk("hold_start_ready", bus4.start_ready, 1'b0);
            chk("hold_done_valid", bus4.done_valid, 1'b1);
        end
        bus4.a = 16'h4000; bus4.b = 16'h4000; bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus4.done_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_start_ready", bus4.start_ready, 1'b1);
        chk("release_done_valid", bus4.done_valid, 1'b0);
        q4.push_back('{16'h8000, 1'b0, 1'b1, cyc + 1});
        @(posedge clk);
        #1 bus4.start_valid = 1'b0;
        chk("accept_after_release", bus4.start_ready, 1'b0);
        @(negedge clk);

        // Reset in the second RUN cycle aborts the operation.
        wait_idle4();
        issue(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_sum", bus4.sum, 16'h0000);
        chk("abort_cout", bus4.cout, 1'b0);
        chk("abort_ovf", bus4.ovf, 1'b0);
        chk("abort_done_valid", bus4.done_valid, 1'b0);
        chk("abort_start_ready", bus4.start_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", bus4.done_valid, 1'b0);
        end
        issue(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);

        k = 0;
        while ((q4.size() != 0 || q16.size() != 0) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("dut4_queue_drained", q4.size(), 0);
        chk("dut16_queue_drained", q16.size(), 0);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
